// File: rtl/ram_fetch_unit.sv
// rtl/ram_fetch_unit.sv - sequential fetch from a sync-read RAM into a 2-entry valid/ready queue
// Optional stop-on-HALT_WORD behaviour is compiled in with FETCH_HALT_EN.
module ram_fetch_unit #(
   parameter int unsigned ADDR_W   = 6,
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned RESET_PC = 0
`ifdef FETCH_HALT_EN
   ,
   parameter logic [DATA_W-1:0] HALT_WORD = 16'hFFFF
`endif
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_addr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_din,
   input  logic [DATA_W-1:0] mem_dout,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [DATA_W-1:0] instr_data,
   output logic [ADDR_W-1:0] instr_pc,
   output logic              halted
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1
`ifdef FETCH_HALT_EN
      ,
      S_HALT = 2'd2
`endif
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [ADDR_W-1:0] r_fetch_pc;
   logic [ADDR_W-1:0] r_rsp_pc;
   logic              r_inflight;
   logic [1:0]        r_count;
   logic [DATA_W-1:0] r_q_data [2];
   logic [ADDR_W-1:0] r_q_pc   [2];

   logic w_pop;
   logic w_push;
   logic w_issue;
   logic w_credit_ok;
   logic w_halt_hit;
   logic w_wr_idx;

   assign w_pop  = (r_count != 2'd0) & instr_ready;
   assign w_push = r_inflight & ~redirect_valid;

`ifdef FETCH_HALT_EN
   assign w_halt_hit = w_push & (mem_dout == HALT_WORD);
`else
   assign w_halt_hit = 1'b0;
`endif

   // Occupancy is taken net of this cycle's pop so a held-high ready sustains one word per cycle.
   assign w_credit_ok = ({1'b0, r_count} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop});
   assign w_issue     = (r_state == S_RUN) & enable & ~redirect_valid & w_credit_ok & ~w_halt_hit;
   assign w_wr_idx    = (r_count == 2'd2) | ((r_count == 2'd1) & ~w_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (redirect_valid) begin
         w_state_nxt = enable ? S_RUN : S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:  if (enable)  w_state_nxt = S_RUN;
            S_RUN:   if (!enable) w_state_nxt = S_IDLE;
            default: w_state_nxt = r_state;
         endcase
`ifdef FETCH_HALT_EN
         if (w_halt_hit) w_state_nxt = S_HALT;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fetch_pc  <= RESET_PC[ADDR_W-1:0];
         r_rsp_pc    <= '0;
         r_inflight  <= 1'b0;
         r_count     <= 2'd0;
         r_q_data[0] <= '0;
         r_q_data[1] <= '0;
         r_q_pc[0]   <= '0;
         r_q_pc[1]   <= '0;
      end else if (redirect_valid) begin
         r_fetch_pc <= redirect_addr;
         r_inflight <= 1'b0;
         r_count    <= 2'd0;
      end else begin
         if (w_issue) begin
            r_fetch_pc <= r_fetch_pc + {{(ADDR_W-1){1'b0}}, 1'b1};
            r_rsp_pc   <= r_fetch_pc;
         end
         r_inflight <= w_issue;
         // Shift first; a push into slot 0 in the same cycle overrides the shifted value.
         if (w_pop) begin
            r_q_data[0] <= r_q_data[1];
            r_q_pc[0]   <= r_q_pc[1];
         end
         if (w_push) begin
            r_q_data[w_wr_idx] <= mem_dout;
            r_q_pc[w_wr_idx]   <= r_rsp_pc;
         end
         r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      end
   end

   assign mem_addr    = r_fetch_pc;
   assign mem_we      = 1'b0;
   assign mem_din     = '0;
   assign instr_valid = (r_count != 2'd0);
   assign instr_data  = r_q_data[0];
   assign instr_pc    = r_q_pc[0];

`ifdef FETCH_HALT_EN
   assign halted = (r_state == S_HALT);
`else
   assign halted = 1'b0;
`endif

endmodule
